// File: rtl/vga_pkg.sv
// Shared definitions for the parametrised VGA timing controller: colour-source
// encodings, default 640x480@60 timing and a constant-width helper.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_BLACK = 2'd3
    } vga_mode_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_CLK_DIV  = 4;
    localparam int DEF_COLOR_W  = 4;
    localparam int DEF_CHK_LOG2 = 5;

    // Bits needed to hold 0..value-1; never less than one so 1-entry ranges still get a bit.
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        while ((1 << bits) < value) begin
            bits = bits + 1;
        end
        if (bits < 1) begin
            bits = 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Pixel request bus between the controller (master) and the frame source (slave).
interface vga_timing_ctrl_if #(
    parameter int COLOR_W = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
);
    logic [3*COLOR_W-1:0] pix_rgb;
    logic                 pix_req;
    logic [X_W-1:0]       pix_x;
    logic [Y_W-1:0]       pix_y;
    logic                 frame_start;

    modport master (
        input  pix_rgb,
        output pix_req,
        output pix_x,
        output pix_y,
        output frame_start
    );

    modport slave (
        output pix_rgb,
        input  pix_req,
        input  pix_x,
        input  pix_y,
        input  frame_start
    );
endinterface

// File: rtl/vga_sync_counter.sv
// Pixel-clock divider, horizontal/vertical position counters and the
// combinational active/sync/frame-end decode derived from them.
module vga_sync_counter
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int X_W      = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int Y_W      = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic           clk,
    input  logic           reset,
    output logic [X_W-1:0] h,
    output logic [Y_W-1:0] v,
    output logic           pe,
    output logic           active,
    output logic           hs,
    output logic           vs,
    output logic           frame_end
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   HS_FIRST = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_LAST  = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   VS_FIRST = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_LAST  = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div;

    // With CLK_DIV=1 the divider is pinned at zero, which equals DIV_LAST, so pe stays high.
    always_ff @(posedge clk) begin
        if (reset) begin
            div <= '0;
            h   <= '0;
            v   <= '0;
        end else begin
            div <= pe ? '0 : div + 1'b1;
            if (pe) begin
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? '0 : v + 1'b1;
                end else begin
                    h <= h + 1'b1;
                end
            end
        end
    end

    assign pe        = (div == DIV_LAST);
    assign active    = (h < H_ACT) && (v < V_ACT);
    assign hs        = (h >= HS_FIRST) && (h <= HS_LAST);
    assign vs        = (v >= VS_FIRST) && (v <= VS_LAST);
    assign frame_end = pe && (h == H_LAST) && (v == V_LAST);

endmodule

// File: rtl/vga_timing_ctrl.sv
// Parametrised VGA controller: frame-aligned colour-source selection and a
// registered output stage one pixel period behind the position counters.
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter int CHK_LOG2 = DEF_CHK_LOG2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          mode,
    vga_timing_ctrl_if.master   pix,
    output logic [COLOR_W-1:0]  VGA_RED,
    output logic [COLOR_W-1:0]  VGA_GREEN,
    output logic [COLOR_W-1:0]  VGA_BLUE,
    output logic                VGA_HSYNC,
    output logic                VGA_VSYNC
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_W     = clog2(H_TOTAL);
    localparam int Y_W     = clog2(V_TOTAL);
    localparam int BAR_W   = H_ACTIVE / 8;

    logic [X_W-1:0] h;
    logic [Y_W-1:0] v;
    logic           pe;
    logic           active;
    logic           hs;
    logic           vs;
    logic           frame_end;

    vga_mode_t      mode_q;
    logic [2:0]     bar;
    logic [COLOR_W-1:0] next_red;
    logic [COLOR_W-1:0] next_green;
    logic [COLOR_W-1:0] next_blue;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV),
        .X_W      (X_W),
        .Y_W      (Y_W)
    ) u_sync (
        .clk       (clk),
        .reset     (reset),
        .h         (h),
        .v         (v),
        .pe        (pe),
        .active    (active),
        .hs        (hs),
        .vs        (vs),
        .frame_end (frame_end)
    );

    assign pix.pix_req     = active;
    assign pix.pix_x       = h;
    assign pix.pix_y       = v;
    assign pix.frame_start = frame_end;

    // Bar index by threshold compares; the last threshold passed wins, so no divider is needed.
    always_comb begin
        bar = '0;
        for (int i = 1; i < 8; i++) begin
            if (h >= X_W'(i * BAR_W)) begin
                bar = 3'(i);
            end
        end
    end

    always_comb begin
        next_red   = '0;
        next_green = '0;
        next_blue  = '0;
        if (active) begin
            case (mode_q)
                MODE_EXT: begin
                    next_red   = pix.pix_rgb[3*COLOR_W-1 -: COLOR_W];
                    next_green = pix.pix_rgb[2*COLOR_W-1 -: COLOR_W];
                    next_blue  = pix.pix_rgb[COLOR_W-1:0];
                end
                MODE_BARS: begin
                    next_red   = {COLOR_W{bar[2]}};
                    next_green = {COLOR_W{bar[1]}};
                    next_blue  = {COLOR_W{bar[0]}};
                end
                MODE_CHECK: begin
                    next_red   = {COLOR_W{h[CHK_LOG2] ^ v[CHK_LOG2]}};
                    next_green = {COLOR_W{h[CHK_LOG2] ^ v[CHK_LOG2]}};
                    next_blue  = {COLOR_W{h[CHK_LOG2] ^ v[CHK_LOG2]}};
                end
                default: begin
                    next_red   = '0;
                    next_green = '0;
                    next_blue  = '0;
                end
            endcase
        end
    end

    // Mode is only taken on the last pixel of a frame so the picture never changes source mid-frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q    <= MODE_EXT;
            VGA_RED   <= '0;
            VGA_GREEN <= '0;
            VGA_BLUE  <= '0;
            VGA_HSYNC <= ~HS_POL;
            VGA_VSYNC <= ~VS_POL;
        end else begin
            if (frame_end) begin
                mode_q <= vga_mode_t'(mode);
            end
            if (pe) begin
                VGA_RED   <= next_red;
                VGA_GREEN <= next_green;
                VGA_BLUE  <= next_blue;
                VGA_HSYNC <= hs ? HS_POL : ~HS_POL;
                VGA_VSYNC <= vs ? VS_POL : ~VS_POL;
            end
        end
    end

endmodule
